// File: rtl/chip8_pkg.sv
// -----------------------------------------------------------------------------
// chip8_pkg
// Shared constants and types for the CHIP-8 style sprite blitter.
//   - Screen geometry (framebuffer pixels, words per row, row count)
//   - Blitter FSM state enum (WAITV exists only when BLIT_VSYNC_WAIT_EN is set)
//   - fb_word_addr(): row/word -> framebuffer word address
// Macro: BLIT_VSYNC_WAIT_EN (optional vertical-blank start gating).
// -----------------------------------------------------------------------------
package chip8_pkg;

    localparam int SCREEN_W      = 128;
    localparam int SCREEN_H      = 64;
    localparam int WORDS_PER_ROW = 8;
    localparam int ROW_COUNT     = 64;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd2,
        FETCH2 = 4'd3,
        FETCH3 = 4'd4,
        RD0    = 4'd5,
        WR0    = 4'd6,
        RD1    = 4'd7,
        WR1    = 4'd8,
        DONE   = 4'd9
`ifdef BLIT_VSYNC_WAIT_EN
        ,
        WAITV  = 4'd1
`endif
    } blit_state_e;

    // 8 words of 16 pixels per row, so the word address is row*8 + word.
    function automatic logic [8:0] fb_word_addr(input logic [5:0] row, input logic [2:0] word);
        return {row, word};
    endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// -----------------------------------------------------------------------------
// sprite_blitter_if
// Memory-side bus of the sprite blitter: sprite ROM/RAM read port and the
// framebuffer read/write port. Both memories return read data one cycle after
// the address is presented.
//   master (blitter): drives spr_addr, fbuf_addr, fbuf_wdata, fbuf_we
//   slave  (memory) : drives spr_data, fbuf_rdata
// -----------------------------------------------------------------------------
interface sprite_blitter_if;

    logic [11:0] spr_addr;
    logic [7:0]  spr_data;
    logic [8:0]  fbuf_addr;
    logic [15:0] fbuf_rdata;
    logic [15:0] fbuf_wdata;
    logic        fbuf_we;

    modport master (
        output spr_addr,
        output fbuf_addr,
        output fbuf_wdata,
        output fbuf_we,
        input  spr_data,
        input  fbuf_rdata
    );

    modport slave (
        input  spr_addr,
        input  fbuf_addr,
        input  fbuf_wdata,
        input  fbuf_we,
        output spr_data,
        output fbuf_rdata
    );

endinterface

// File: rtl/sprite_row_expand.sv
// -----------------------------------------------------------------------------
// sprite_row_expand
// Combinational: turns one sprite row into the two framebuffer XOR masks.
//   byte_hi_i/byte_lo_i : sprite row bytes (lo is 0 for 8-px sprites)
//   hires_i             : 0 doubles every sprite bit horizontally (lores)
//   shift_i             : pixel offset inside the first framebuffer word
//   mask0_o/mask1_o     : masks for word w0 and word w0+1
// -----------------------------------------------------------------------------
module sprite_row_expand (
    input  logic [7:0]  byte_hi_i,
    input  logic [7:0]  byte_lo_i,
    input  logic        hires_i,
    input  logic [3:0]  shift_i,
    output logic [15:0] mask0_o,
    output logic [15:0] mask1_o
);

    logic [15:0] pattern;
    logic [31:0] shifted;

    always_comb begin
        pattern = {byte_hi_i, byte_lo_i};
        if (!hires_i) begin
            // Each lores pixel covers two adjacent framebuffer pixels.
            for (int b = 0; b < 8; b++) begin
                pattern[2*b]   = byte_hi_i[b];
                pattern[2*b+1] = byte_hi_i[b];
            end
        end
        // Place the 16-px pattern across a 32-px window starting at word w0.
        shifted = {pattern, 16'h0000} >> shift_i;
        mask0_o = shifted[31:16];
        mask1_o = shifted[15:0];
    end

endmodule

// File: rtl/sprite_blitter.sv
// -----------------------------------------------------------------------------
// sprite_blitter
// XOR-draws a CHIP-8/SCHIP sprite into a 64x8-word (128x64 px) framebuffer,
// reporting collision when any set pixel is flipped off.
// Ports:
//   clk, res (sync, active-low)
//   hires        : 1 = 128x64, 0 = 64x32 with 2x2 pixel doubling
//   start        : one-cycle draw request, ignored while busy
//   x, y, n      : sprite position and row count (n=0 -> 16 rows; 16x16 in hires)
//   i_addr       : sprite base address
//   bus          : sprite memory + framebuffer bus (sprite_blitter_if.master)
//   beam_outside : display is not scanning the framebuffer
//   busy, done, collision
// Macro: BLIT_VSYNC_WAIT_EN -- when defined, drawing waits in WAITV until
// beam_outside is high; otherwise beam_outside is ignored.
// -----------------------------------------------------------------------------
module sprite_blitter
    import chip8_pkg::*;
(
    input  logic             clk,
    input  logic             res,
    input  logic             hires,
    input  logic             start,
    input  logic [6:0]       x,
    input  logic [5:0]       y,
    input  logic [3:0]       n,
    input  logic [11:0]      i_addr,
    sprite_blitter_if.master bus,
    input  logic             beam_outside,
    output logic             busy,
    output logic             done,
    output logic             collision
);

    blit_state_e state_q, state_d;
    logic        coll_q, coll_d;

    logic        hires_q, hires_d;
    logic        wide_q, wide_d;
    logic [11:0] base_q, base_d;
    logic [6:0]  col_q, col_d;       // framebuffer pixel column of the sprite
    logic [6:0]  fb_row_q, fb_row_d; // extra bit flags running past row 63
    logic [4:0]  row_q, row_d;       // sprite row being drawn
    logic [4:0]  rows_q, rows_d;     // total sprite rows
    logic        sub_q, sub_d;       // lores: second framebuffer copy of the row
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;

    logic [15:0] mask0, mask1;
    logic [2:0]  w0;
    logic [11:0] row_addr;
    logic [6:0]  fb_row_nx;
    logic [4:0]  row_nx;
    logic        adv;

    logic [11:0] spr_addr_c;
    logic [8:0]  fbuf_addr_c;
    logic [15:0] fbuf_wdata_c;
    logic        fbuf_we_c;

`ifndef BLIT_VSYNC_WAIT_EN
    logic unused_beam_outside;
    assign unused_beam_outside = beam_outside;
`endif

    sprite_row_expand u_expand (
        .byte_hi_i (hi_q),
        .byte_lo_i (lo_q),
        .hires_i   (hires_q),
        .shift_i   (col_q[3:0]),
        .mask0_o   (mask0),
        .mask1_o   (mask1)
    );

    assign w0        = col_q[6:4];
    assign fb_row_nx = fb_row_q + 7'd1;
    assign row_nx    = row_q + 5'd1;
    assign row_addr  = base_q + (wide_q ? {6'b0, row_q, 1'b0} : {7'b0, row_q});

    always_comb begin
        state_d  = state_q;
        coll_d   = coll_q;
        hires_d  = hires_q;
        wide_d   = wide_q;
        base_d   = base_q;
        col_d    = col_q;
        fb_row_d = fb_row_q;
        row_d    = row_q;
        rows_d   = rows_q;
        sub_d    = sub_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        adv      = 1'b0;
        spr_addr_c   = 12'h000;
        fbuf_addr_c  = 9'h000;
        fbuf_wdata_c = 16'h0000;
        fbuf_we_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    hires_d  = hires;
                    wide_d   = hires && (n == 4'd0);
                    base_d   = i_addr;
                    // Lores coordinates wrap at 64x32 and are doubled onto the framebuffer.
                    col_d    = hires ? x : {x[5:0], 1'b0};
                    fb_row_d = hires ? {1'b0, y} : {1'b0, y[4:0], 1'b0};
                    rows_d   = (n == 4'd0) ? 5'd16 : {1'b0, n};
                    row_d    = 5'd0;
                    sub_d    = 1'b0;
                    coll_d   = 1'b0;
`ifdef BLIT_VSYNC_WAIT_EN
                    state_d  = WAITV;
`else
                    state_d  = FETCH;
`endif
                end
            end
`ifdef BLIT_VSYNC_WAIT_EN
            WAITV: begin
                if (beam_outside) state_d = FETCH;
            end
`endif
            FETCH: begin
                spr_addr_c = row_addr;
                state_d    = FETCH2;
            end
            FETCH2: begin
                hi_d = bus.spr_data;
                lo_d = 8'h00;
                if (wide_q) begin
                    spr_addr_c = row_addr + 12'd1;
                    state_d    = FETCH3;
                end else begin
                    state_d    = RD0;
                end
            end
            FETCH3: begin
                lo_d    = bus.spr_data;
                state_d = RD0;
            end
            RD0: begin
                fbuf_addr_c = fb_word_addr(fb_row_q[5:0], w0);
                state_d     = WR0;
            end
            WR0: begin
                fbuf_addr_c  = fb_word_addr(fb_row_q[5:0], w0);
                fbuf_wdata_c = bus.fbuf_rdata ^ mask0;
                fbuf_we_c    = 1'b1;
                if ((bus.fbuf_rdata & mask0) != 16'h0000) coll_d = 1'b1;
                // Second word is off-screen or untouched: skip its read-modify-write.
                if (w0 == 3'd7 || mask1 == 16'h0000) adv = 1'b1;
                else state_d = RD1;
            end
            RD1: begin
                fbuf_addr_c = fb_word_addr(fb_row_q[5:0], w0 + 3'd1);
                state_d     = WR1;
            end
            WR1: begin
                fbuf_addr_c  = fb_word_addr(fb_row_q[5:0], w0 + 3'd1);
                fbuf_wdata_c = bus.fbuf_rdata ^ mask1;
                fbuf_we_c    = 1'b1;
                if ((bus.fbuf_rdata & mask1) != 16'h0000) coll_d = 1'b1;
                adv = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // End of a framebuffer row: lores repeats the same byte on the next
        // row, otherwise move on to the next sprite row. Drawing stops at the
        // bottom edge.
        if (adv) begin
            fb_row_d = fb_row_nx;
            if (!hires_q && !sub_q) begin
                sub_d   = 1'b1;
                state_d = fb_row_nx[6] ? DONE : RD0;
            end else begin
                sub_d   = 1'b0;
                row_d   = row_nx;
                state_d = (row_nx == rows_q || fb_row_nx[6]) ? DONE : FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q <= IDLE;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            coll_q  <= coll_d;
        end
    end

    always_ff @(posedge clk) begin
        hires_q  <= hires_d;
        wide_q   <= wide_d;
        base_q   <= base_d;
        col_q    <= col_d;
        fb_row_q <= fb_row_d;
        row_q    <= row_d;
        rows_q   <= rows_d;
        sub_q    <= sub_d;
        hi_q     <= hi_d;
        lo_q     <= lo_d;
    end

    assign bus.spr_addr   = spr_addr_c;
    assign bus.fbuf_addr  = fbuf_addr_c;
    assign bus.fbuf_wdata = fbuf_wdata_c;
    assign bus.fbuf_we    = fbuf_we_c;

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign collision = coll_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// -----------------------------------------------------------------------------
// tb_sprite_blitter
// Directed bench for sprite_blitter with behavioural sprite memory and
// framebuffer (both one-cycle read latency).
// -----------------------------------------------------------------------------
module tb_sprite_blitter;

    logic        clk;
    logic        res;
    logic        hires;
    logic        start;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [3:0]  n;
    logic [11:0] i_addr;
    logic        beam_outside;
    logic        busy;
    logic        done;
    logic        collision;

    sprite_blitter_if bus();

    sprite_blitter dut (
        .clk          (clk),
        .res          (res),
        .hires        (hires),
        .start        (start),
        .x            (x),
        .y            (y),
        .n            (n),
        .i_addr       (i_addr),
        .bus          (bus.master),
        .beam_outside (beam_outside),
        .busy         (busy),
        .done         (done),
        .collision    (collision)
    );

    logic [7:0]  spr_mem [4096];
    logic [15:0] fb      [512];
    int          hits    [512];
    int          wr_cnt;
    logic        clr;

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.spr_data   <= spr_mem[bus.spr_addr];
        bus.fbuf_rdata <= fb[bus.fbuf_addr];
        if (clr) begin
            for (int i = 0; i < 512; i++) fb[i] <= 16'h0000;
        end else if (bus.fbuf_we) begin
            fb[bus.fbuf_addr]   <= bus.fbuf_wdata;
            hits[bus.fbuf_addr] <= hits[bus.fbuf_addr] + 1;
            wr_cnt              <= wr_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_fb();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic run_blit(input logic h, input logic [6:0] xx, input logic [5:0] yy,
                            input logic [3:0] nn, input logic [11:0] aa,
                            output int cyc, output int nwr, output logic we_before);
        int   w_start;
        logic prev_we;
        @(negedge clk);
        hires  = h;
        x      = xx;
        y      = yy;
        n      = nn;
        i_addr = aa;
        start  = 1'b1;
        w_start = wr_cnt;
        @(posedge clk);
        #1 start = 1'b0;
        cyc       = 0;
        prev_we   = 1'b0;
        we_before = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (done) we_before = prev_we;
            prev_we = bus.fbuf_we;
        end
        check_eq("done_seen", 32'(done), 1);
        @(posedge clk);
        #1;
        nwr = wr_cnt - w_start;
    endtask

    initial begin
        int   cyc;
        int   nwr;
        int   exp_cyc;
        int   h503;
        int   h511;
        int   wsnap;
        logic web;
        bit   hit;

        n_cmp        = 0;
        n_err        = 0;
        wr_cnt       = 0;
        clr          = 1'b0;
        res          = 1'b0;
        hires        = 1'b0;
        start        = 1'b0;
        x            = '0;
        y            = '0;
        n            = '0;
        i_addr       = '0;
        beam_outside = 1'b1;
        for (int i = 0; i < 4096; i++) spr_mem[i] = 8'h00;
        for (int i = 0; i < 512; i++) hits[i] = 0;

        spr_mem[12'h100] = 8'hFF;
        spr_mem[12'h101] = 8'hF0;
        spr_mem[12'h102] = 8'hFF;
        for (int i = 0; i < 4; i++) spr_mem[12'h110 + i] = 8'hFF;
        spr_mem[12'h120] = 8'h80;
        spr_mem[12'h200] = 8'h12;
        spr_mem[12'h201] = 8'h34;
        spr_mem[12'h21E] = 8'hAB;
        spr_mem[12'h21F] = 8'hCD;
        for (int i = 0; i < 5; i++) spr_mem[12'h130 + i] = 8'hFF;
        spr_mem[12'h140] = 8'hFF;

`ifdef BLIT_VSYNC_WAIT_EN
        exp_cyc = 6;
`else
        exp_cyc = 5;
`endif

        clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        check_eq("rst_busy",      32'(busy), 0);
        check_eq("rst_done",      32'(done), 0);
        check_eq("rst_coll",      32'(collision), 0);
        check_eq("rst_we",        32'(bus.fbuf_we), 0);
        check_eq("rst_spr_addr",  32'(bus.spr_addr), 0);
        check_eq("rst_fbuf_addr", 32'(bus.fbuf_addr), 0);
        res = 1'b1;

        // hires 8x1 byte FF at the origin
        run_blit(1'b1, 7'd0, 6'd0, 4'd1, 12'h100, cyc, nwr, web);
        check_eq("t1_word0",   32'(fb[0]), 'hFF00);
        check_eq("t1_word1",   32'(fb[1]), 'h0000);
        check_eq("t1_writes",  nwr, 1);
        check_eq("t1_coll",    32'(collision), 0);
        check_eq("t1_cycles",  cyc, exp_cyc);
        check_eq("t1_wr_last", 32'(web), 1);
        check_eq("t1_busy",    32'(busy), 0);

        // x=12, byte F0: only word 0 touched
        clear_fb();
        run_blit(1'b1, 7'd12, 6'd0, 4'd1, 12'h101, cyc, nwr, web);
        check_eq("t2_word0",  32'(fb[0]), 'h000F);
        check_eq("t2_word1",  32'(fb[1]), 'h0000);
        check_eq("t2_writes", nwr, 1);
        check_eq("t2_coll",   32'(collision), 0);

        // same sprite again erases it and collides
        run_blit(1'b1, 7'd12, 6'd0, 4'd1, 12'h101, cyc, nwr, web);
        check_eq("t3_word0",  32'(fb[0]), 'h0000);
        check_eq("t3_writes", nwr, 1);
        check_eq("t3_coll",   32'(collision), 1);

        // x=12, byte FF straddles words 0/1 of row 5
        clear_fb();
        run_blit(1'b1, 7'd12, 6'd5, 4'd1, 12'h102, cyc, nwr, web);
        check_eq("t3b_w40",    32'(fb[40]), 'h000F);
        check_eq("t3b_w41",    32'(fb[41]), 'hF000);
        check_eq("t3b_writes", nwr, 2);
        check_eq("t3b_coll",   32'(collision), 0);

        // bottom-right corner clipping
        clear_fb();
        h503 = hits[503];
        h511 = hits[511];
        run_blit(1'b1, 7'd124, 6'd62, 4'd4, 12'h110, cyc, nwr, web);
        check_eq("t4_w503",    32'(fb[503]), 'h000F);
        check_eq("t4_w511",    32'(fb[511]), 'h000F);
        check_eq("t4_writes",  nwr, 2);
        check_eq("t4_hit503",  hits[503] - h503, 1);
        check_eq("t4_hit511",  hits[511] - h511, 1);
        check_eq("t4_coll",    32'(collision), 0);

        // lores pixel doubling
        clear_fb();
        run_blit(1'b0, 7'd0, 6'd0, 4'd1, 12'h120, cyc, nwr, web);
        check_eq("t5_row0",   32'(fb[0]), 'hC000);
        check_eq("t5_row1",   32'(fb[8]), 'hC000);
        check_eq("t5_writes", nwr, 2);

        // lores coordinate wrap: x=70 -> 6, y=33 -> 1
        clear_fb();
        run_blit(1'b0, 7'd70, 6'd33, 4'd1, 12'h120, cyc, nwr, web);
        check_eq("t5w_row2",   32'(fb[16]), 'h000C);
        check_eq("t5w_row3",   32'(fb[24]), 'h000C);
        check_eq("t5w_writes", nwr, 2);

        // 16x16 hires sprite
        clear_fb();
        run_blit(1'b1, 7'd0, 6'd10, 4'd0, 12'h200, cyc, nwr, web);
        check_eq("t6_row10",  32'(fb[80]), 'h1234);
        check_eq("t6_row25",  32'(fb[200]), 'hABCD);
        check_eq("t6_writes", nwr, 16);

        // reset during WR0 of sprite row 2
        clear_fb();
        run_blit(1'b1, 7'd0, 6'd1, 4'd1, 12'h140, cyc, nwr, web);
        check_eq("t7_pre_w8", 32'(fb[8]), 'hFF00);
        @(negedge clk);
        x      = 7'd0;
        y      = 6'd0;
        n      = 4'd5;
        i_addr = 12'h130;
        hires  = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            if (bus.fbuf_we && bus.fbuf_addr == 9'd16) hit = 1'b1;
        end
        check_eq("t7_reach_wr0", 32'(hit), 1);
        check_eq("t7_coll_pre",  32'(collision), 1);
        res = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t7_busy",      32'(busy), 0);
        check_eq("t7_coll",      32'(collision), 0);
        check_eq("t7_done",      32'(done), 0);
        check_eq("t7_we",        32'(bus.fbuf_we), 0);
        check_eq("t7_spr_addr",  32'(bus.spr_addr), 0);
        check_eq("t7_fbuf_addr", 32'(bus.fbuf_addr), 0);
        @(negedge clk);
        res = 1'b1;
        wsnap = wr_cnt;
        repeat (20) @(negedge clk);
        check_eq("t7_no_writes", wr_cnt - wsnap, 0);
        check_eq("t7_row0",      32'(fb[0]), 'hFF00);
        check_eq("t7_row1",      32'(fb[8]), 'h0000);
        check_eq("t7_row3",      32'(fb[24]), 'h0000);
        check_eq("t7_row4",      32'(fb[32]), 'h0000);
        check_eq("t7_idle",      32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have ports: res  in  1  synchronous reset, active-low.
REQ-003 SHALL have ports: hires  in  1  1 = 128x64 mode; 0 = 64x32 mode with 2x2 pixel doubling.
REQ-004 SHALL have ports: start  in  1  one-cycle draw request; ignored while busy.
REQ-005 SHALL have ports: x  in  7  sprite X; y  in  6  sprite Y; n  in  4  row count; i_addr  in  12  sprite base address. All sampled on start.
REQ-006 SHALL have ports: spr_addr  out  12  sprite memory address; spr_data  in  8  sprite byte, valid one cycle after spr_addr.
REQ-007 SHALL have ports: fbuf_addr  out  9  framebuffer word address; fbuf_rdata  in  16  read data, valid one cycle after fbuf_addr.
REQ-008 SHALL have ports: fbuf_wdata  out  16  write data; fbuf_we  out  1  write strobe, one word per cycle.
REQ-009 SHALL have ports: beam_outside  in  1  high while the display is not scanning the framebuffer.
REQ-010 SHALL have ports: busy  out  1; done  out  1  one-cycle pulse; collision  out  1  VF result, held until next start.

Function
REQ-011 Framebuffer layout SHALL be 64 rows x 8 words; word address = row*8 + col/16; MSB of a word = leftmost pixel.
REQ-012 Sprite width SHALL be 16 px (2 bytes per row, high byte first, 32 bytes) when n=0 and hires=1; otherwise 8 px with n rows, n=0 meaning 16 rows.
REQ-013 Start coordinates SHALL wrap: hires x mod 128, y mod 64; lores x mod 64, y mod 32.
REQ-014 Pixels beyond the right or bottom screen edge SHALL be clipped, with no write and no collision contribution.
REQ-015 Lores SHALL expand each sprite bit to 2 adjacent framebuffer bits and write each logical row to framebuffer rows 2y and 2y+1.
REQ-016 States SHALL be IDLE, WAITV, FETCH, FETCH2, FETCH3, RD0, WR0, RD1, WR1, and DONE.
REQ-017 IDLE SHALL move on start to WAITV when BLIT_VSYNC_WAIT_EN is defined, otherwise to FETCH; WAITV SHALL move to FETCH when beam_outside=1.
REQ-018 FETCH SHALL drive spr_addr = i_addr + row*bytes_per_row; FETCH2 SHALL capture the byte and, for 16-px sprites, drive the next address; FETCH3 SHALL capture the low byte.
REQ-019 For each framebuffer row, RD0, WR0, RD1 and WR1 SHALL perform read-XOR-write on word w0 = col/16, then w0+1, using the shifted masks (shift = col mod 16).
REQ-020 RD1/WR1 SHALL be skipped with no fbuf_we when w0=7 or mask1=0.
REQ-021 collision SHALL be 1 if any (rdata AND mask) != 0 during the draw.
REQ-022 Rows SHALL continue until all rows are drawn or the next framebuffer row exceeds 63, then move to DONE.
REQ-023 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 fbuf_we SHALL be high only in WR0/WR1; fbuf_wdata = fbuf_rdata XOR mask.
REQ-026 Address arithmetic SHALL be 12-bit and wrap modulo 4096.

Reset
REQ-027 While res=0 at a clock edge the block SHALL enter IDLE with busy=0, done=0, collision=0, fbuf_we=0, spr_addr=0 and fbuf_addr=0.
REQ-028 Reset during a draw SHALL abort it immediately, with no further write.

Configuration
REQ-029 With BLIT_VSYNC_WAIT_EN defined the block SHALL gate drawing start on beam_outside (WAITV state); without it WAITV SHALL be absent and beam_outside SHALL be ignored.

Structure
REQ-030 Package chip8_pkg SHALL hold the screen width, height, words-per-row and row-count constants, and the blitter state enum.
REQ-031 Sub-module sprite_row_expand SHALL be combinational: byte(s), hires and shift in; mask0/mask1 out.

Verification
REQ-032 Bench SHALL cover: hires, x=0, y=0, n=1, byte 0xFF, empty fb -> word0=0xFF00, one write, collision=0, done after WR0.
REQ-033 Bench SHALL cover: hires, x=12, byte 0xF0 -> word0 &=0x000F set, word1=0x0000 untouched because mask1=0, no RD1/WR1.
REQ-034 Bench SHALL cover: redraw of the same sprite -> words return to 0, collision=1.
REQ-035 Bench SHALL cover: hires, x=124, y=62, n=4, 0xFF -> only word 7 in rows 62..63 written, no w0+1 write, 2 rows drawn.
REQ-036 Bench SHALL cover: lores, x=0, y=0, n=1, byte 0x80 -> rows 0 and 1, word0=0xC000 each.
REQ-037 Bench SHALL cover: reset asserted in WR0 of row 2 -> rows 3+ untouched, busy=0 and collision=0 after the edge.
